fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front end on the producer side of the issue interface.
- Owns the fetch PC and drives the instruction memory address; holds fetched instructions in a small circular FIFO.
- Presents the FIFO head to the Tomasulo issue stage, which applies back-pressure through A_stall/LS_stall.
- Decouples fetch from issue stalls, supports redirect (flush), and raises a done indication after an end-of-program marker.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- END_MARKER, 32'h0000_0000, instruction word that terminates fetch.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_addr  output  32  fetch PC driven to instruction memory (combinational-read memory)
- imem_rdata  input  32  instruction word at imem_addr, same cycle
- A_stall  input  1  arithmetic reservation stations full; issue must not consume
- LS_stall  input  1  load/store buffer full; issue must not consume
- flush  input  1  redirect request
- flush_pc  input  32  redirect target, sampled when flush=1
- issue_instr  output  32  head-entry instruction; 0 when empty
- issue_pc  output  32  head-entry PC; 0 when empty
- issue_valid  output  1  head entry present
- occupancy  output  $clog2(DEPTH)+1  entries held
- fetch_done  output  1  end marker fetched and FIFO drained

Behaviour:
- Reset (synchronous, highest priority):
  - pc=RESET_PC; head/tail pointers=0; count=0; halted=0.
  - issue_valid=0, issue_instr=0, issue_pc=0, occupancy=0, fetch_done=0.
  - Any in-flight FIFO contents are discarded.
- imem_addr=pc, combinational from the pc register.
- Pop: pop = issue_valid && !A_stall && !LS_stall. Head advances on the clock edge where pop=1.
- Push: push = !halted && (count<DEPTH) && (imem_rdata!=END_MARKER).
  - The full check uses the count at the start of the cycle; a simultaneous pop does not enable a push into a full FIFO.
  - On push: entry[tail]={imem_rdata, pc}; tail advances; pc<=pc+4. Wraps modulo 2^32; no overflow flag.
- End marker: when !halted, count<DEPTH and imem_rdata==END_MARKER:
  - halted<=1; nothing is enqueued; pc holds.
  - While halted, there are no further pushes; pops continue.
- Full: pc holds; no push; imem_addr is stable until space frees.
- Count update: count += push − pop. A simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Latency:
  - An instruction fetched in cycle N is visible at issue_* in cycle N+1.
  - There is no bypass from imem_rdata to issue_* when empty.
- Outputs issue_* come directly from entry[head] and are 0 when count==0.
- Flush (priority below reset, above push/pop):
  - count=0, head=tail=0, pc<=flush_pc, halted<=0.
  - Any pop or push in the same cycle is ignored.
  - Fetch resumes at flush_pc in the next cycle.
- fetch_done=halted && count==0, registered-state derived. Stays 1 until reset or flush.
- occupancy=count.

Test Plan:
- Reset then imem returns 32'h0000_0093 at PC 0, 4, 8 with no stalls → cycle 1 issue_pc=0, valid=1; one instruction issued per cycle, issue_pc 0, 4, 8; occupancy holds at 1.
- Hold A_stall=1 for 6 cycles with DEPTH=4 → occupancy reaches 4; imem_addr frozen at 16; A_stall=0 → pops resume in order with PCs 0, 4, 8, 12, and pc advances.
- Full FIFO with LS_stall=0 for one cycle → one pop and no push that cycle; occupancy 4→3, then a push the next cycle restores it to 4.
- END_MARKER fetched at PC 12 after three valid instructions → halted; no enqueue of PC 12; fetch_done=1 the cycle after the third pop; imem_addr stays 12.
- flush=1 with flush_pc=32'h0000_0100 while 3 entries are queued and stalled → next cycle occupancy=0, issue_valid=0, imem_addr=0x100; following cycle issue_pc=0x100.
- Assert reset mid-stream with occupancy 2 and halted=1 → next cycle all outputs 0; imem_addr=RESET_PC; fetch restarts normally.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC and buffers fetched words in a
// circular FIFO whose head is offered to the issue stage.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] END_MARKER = 32'h0000_0000,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            A_stall,
  input  logic            LS_stall,
  input  logic            flush,
  input  logic [31:0]     flush_pc,
  output logic [31:0]     issue_instr,
  output logic [31:0]     issue_pc,
  output logic            issue_valid,
  output logic [CntW-1:0] occupancy,
  output logic            fetch_done
);

  logic [31:0]     pc_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            halted_q;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     entry_pc_q [DEPTH];

  logic not_full, push, pop, marker_hit;

  // Fullness uses the start-of-cycle count, so a pop never frees room for a same-cycle push.
  always_comb begin
    not_full   = count_q < CntW'(DEPTH);
    push       = !halted_q && not_full && (imem_rdata != END_MARKER);
    marker_hit = !halted_q && not_full && (imem_rdata == END_MARKER);
    pop        = issue_valid && !A_stall && !LS_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (flush) begin
      pc_q     <= flush_pc;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        instr_q[tail_q]    <= imem_rdata;
        entry_pc_q[tail_q] <= pc_q;
        tail_q             <= tail_q + PtrW'(1);
        pc_q               <= pc_q + 32'd4;
      end
      if (pop) begin
        head_q <= head_q + PtrW'(1);
      end
      if (marker_hit) begin
        halted_q <= 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    imem_addr   = pc_q;
    issue_valid = count_q != '0;
    issue_instr = issue_valid ? instr_q[head_q] : 32'h0;
    issue_pc    = issue_valid ? entry_pc_q[head_q] : 32'h0;
    occupancy   = count_q;
    fetch_done  = halted_q && (count_q == '0);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a small combinational instruction memory feeds the
// DUT and each step compares outputs against hand-worked values.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        A_stall, LS_stall, flush;
  logic [31:0] flush_pc;
  logic [31:0] issue_instr, issue_pc;
  logic        issue_valid;
  logic [2:0]  occupancy;
  logic        fetch_done;

  logic [31:0] imem [256];
  int n_checks = 0;
  int n_bad    = 0;

  fetch_queue #(
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .END_MARKER(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .A_stall    (A_stall),
    .LS_stall   (LS_stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .issue_instr(issue_instr),
    .issue_pc   (issue_pc),
    .issue_valid(issue_valid),
    .occupancy  (occupancy),
    .fetch_done (fetch_done)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[9:2]];

  // Distinct nonzero word per address so instruction/PC pairing is checked too.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h0000_0093 | (addr << 10);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic vld, input logic [31:0] pc,
                             input logic [2:0] occ, input logic [31:0] addr, input logic done);
    check_eq({tag, ".valid"}, 32'(issue_valid), 32'(vld));
    check_eq({tag, ".pc"}, issue_pc, vld ? pc : 32'h0);
    check_eq({tag, ".instr"}, issue_instr, vld ? word_at(pc) : 32'h0);
    check_eq({tag, ".occ"}, 32'(occupancy), 32'(occ));
    check_eq({tag, ".addr"}, imem_addr, addr);
    check_eq({tag, ".done"}, 32'(fetch_done), 32'(done));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = word_at(32'(i) << 2);
    reset = 1'b1; A_stall = 1'b0; LS_stall = 1'b0; flush = 1'b0; flush_pc = '0;
    tick(); tick();
    check_state("reset", 1'b0, 0, 3'd0, 32'h0, 1'b0);
    reset = 1'b0;

    // Streaming with no stalls: one issued per cycle, occupancy stays at 1.
    tick(); check_state("stream0", 1'b1, 32'h0, 3'd1, 32'h4, 1'b0);
    tick(); check_state("stream1", 1'b1, 32'h4, 3'd1, 32'h8, 1'b0);
    tick(); check_state("stream2", 1'b1, 32'h8, 3'd1, 32'hc, 1'b0);

    // Fill under A_stall, then one pop from full without a same-cycle push.
    reset = 1'b1; A_stall = 1'b1;
    tick(); check_state("reset2", 1'b0, 0, 3'd0, 32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_state("full", 1'b1, 32'h0, 3'd4, 32'h10, 1'b0);
    A_stall = 1'b0;
    tick(); check_state("full_pop", 1'b1, 32'h4, 3'd3, 32'h10, 1'b0);
    A_stall = 1'b1;
    tick(); check_state("refill", 1'b1, 32'h4, 3'd4, 32'h14, 1'b0);
    A_stall = 1'b0;
    tick(); check_state("drain0", 1'b1, 32'h8, 3'd3, 32'h14, 1'b0);
    tick(); check_state("drain1", 1'b1, 32'hc, 3'd3, 32'h18, 1'b0);
    LS_stall = 1'b1;
    tick(); check_state("ls_hold", 1'b1, 32'hc, 3'd4, 32'h1c, 1'b0);
    LS_stall = 1'b0;

    // End marker at PC 12 after three real instructions.
    imem[3] = 32'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); check_state("end0", 1'b1, 32'h0, 3'd1, 32'h4, 1'b0);
    tick(); check_state("end1", 1'b1, 32'h4, 3'd1, 32'h8, 1'b0);
    tick(); check_state("end2", 1'b1, 32'h8, 3'd1, 32'hc, 1'b0);
    tick(); check_state("halt", 1'b0, 0, 3'd0, 32'hc, 1'b1);
    tick(); check_state("halt_hold", 1'b0, 0, 3'd0, 32'hc, 1'b1);

    // Flush out of the halted state clears fetch_done.
    imem[3] = word_at(32'hc);
    flush = 1'b1; flush_pc = 32'h0;
    tick(); check_state("unhalt", 1'b0, 0, 3'd0, 32'h0, 1'b0);
    flush = 1'b0; A_stall = 1'b1;
    tick(); tick(); tick();
    check_state("queued3", 1'b1, 32'h0, 3'd3, 32'hc, 1'b0);

    // Redirect with entries queued and stalled.
    flush = 1'b1; flush_pc = 32'h100;
    tick(); check_state("flush", 1'b0, 0, 3'd0, 32'h100, 1'b0);
    flush = 1'b0;
    tick(); check_state("post_flush", 1'b1, 32'h100, 3'd1, 32'h104, 1'b0);

    // Reset while halted with two entries held.
    imem[66] = 32'h0;
    tick(); check_state("pre_halt", 1'b1, 32'h100, 3'd2, 32'h108, 1'b0);
    tick(); check_state("halt2", 1'b1, 32'h100, 3'd2, 32'h108, 1'b0);
    reset = 1'b1;
    tick(); check_state("mid_reset", 1'b0, 0, 3'd0, 32'h0, 1'b0);
    reset = 1'b0; A_stall = 1'b0;
    tick(); check_state("restart0", 1'b1, 32'h0, 3'd1, 32'h4, 1'b0);
    tick(); check_state("restart1", 1'b1, 32'h4, 3'd1, 32'h8, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
